// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave backed by a word-addressed on-chip memory,
// with a configurable number of wait states per data phase.
// Optional feature macro: AHB_SRAM_ERR_EN. When it is defined, out-of-range,
// misaligned and oversize (hsize>2) accesses get a two-cycle ERROR response.
// When it is undefined, the offset wraps modulo MEM_BYTES, misaligned address
// bits are ignored, hsize>2 acts as a word access and hresp stays 0.
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);
    localparam int unsigned AW    = $clog2(MEM_BYTES);
    localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;
    localparam int unsigned DEPTH = 1 << IW;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    be_q, be_d;
    logic          write_q, write_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0] offset;
    logic [3:0]  be_addr;
    logic        accept;
    logic        err_flag;
    logic        mem_we;
    logic        unused_bits;

    // hburst is informational only: every beat carries its own haddr
    assign offset      = haddr - BASE_ADDR;
    assign unused_bits = ^{hburst, htrans[0], offset};

    // New transfers are only taken while this slave is not stalling the bus
    assign accept = hsel && hready && htrans[1] && hreadyout;

`ifdef AHB_SRAM_ERR_EN
    // Error classification of the address-phase request
    always_comb begin
        err_flag = 1'b0;
        if ((haddr < BASE_ADDR) || (offset >= 32'(MEM_BYTES))) err_flag = 1'b1;
        if ((hsize == 3'd1) && haddr[0])                       err_flag = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))          err_flag = 1'b1;
        if (hsize > 3'd2)                                      err_flag = 1'b1;
    end
`else
    assign err_flag = 1'b0;
`endif

    // Little-endian byte-lane enables; unaligned low bits are dropped
    always_comb begin
        case (hsize)
            3'd0:    be_addr = 4'b0001 << haddr[1:0];
            3'd1:    be_addr = haddr[1] ? 4'b1100 : 4'b0011;
            default: be_addr = 4'b1111;
        endcase
    end

    // Next-state: IDLE, DATA and ERR2 all end a data phase this cycle, so a
    // pipelined request is taken in any of them using the same rules
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        be_d    = be_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_DATA;
                else             cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = IW'(offset >> 2);
                    be_d    = be_addr;
                    write_d = hwrite;
                    if (err_flag) begin
                        state_d = S_ERR1;
                    end else if (WS != '0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS - 4'd1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    // Control registers with asynchronous reset
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    // A write commits at the end of its DATA cycle; a reset in flight drops it.
    // The combinational read below then sees it on the very next cycle, which
    // covers the read-after-write case without a bypass path.
    assign mem_we = (state_q == S_DATA) && write_q && !hreset;

    // Memory write port (contents are not reset)
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    assign hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : '0;
`ifdef AHB_SRAM_ERR_EN
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
    assign hresp     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: three slave instances (zero-wait, two-wait with offset
// base, three-wait) share one pipelined master. The driver pushes expected
// data-phase responses; the monitor pops them as each data phase completes.
module tb_ahb_sram_slave;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2;
    localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic        hready;
    logic        ro0, ro1, ro2, rs0, rs1, rs2;
    logic [31:0] rd0, rd1, rd2;

    always #5 hclk = ~hclk;
    assign hready = ro0 & ro1 & ro2;

    ahb_sram_slave #(.BASE_ADDR(32'h0000_0000), .MEM_BYTES(1024), .WAIT_STATES(0)) u_d0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));
    ahb_sram_slave #(.BASE_ADDR(32'h0000_1000), .MEM_BYTES(256), .WAIT_STATES(2)) u_d1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro1), .hresp(rs1), .hrdata(rd1));
    ahb_sram_slave #(.BASE_ADDR(32'h0000_0000), .MEM_BYTES(1024), .WAIT_STATES(3)) u_d2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[2]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hreadyout(ro2), .hresp(rs2), .hrdata(rd2));

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          lowc = 0;
    logic [31:0] pend = 32'h0;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic get_ro(input int d);
        return (d == 0) ? ro0 : (d == 1) ? ro1 : ro2;
    endfunction

    function automatic logic get_rs(input int d);
        return (d == 0) ? rs0 : (d == 1) ? rs1 : rs2;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One address phase; d=3 selects no slave. Holds the request until the bus
    // is ready, then records the expected response of the resulting data phase.
    task automatic issue(input int d, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                         input logic er, input string tag);
        int   budget;
        exp_t e;
        @(negedge hclk);
        hwdata = pend;
        hsel   = (d < 3) ? (3'b001 << d) : 3'b000;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hburst = 3'd1;
        #1;
        budget = 0;
        while (!hready && budget < 40) begin
            @(negedge hclk);
            #1;
            budget++;
        end
        if (!hready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: hready stuck low, got 0 expected 1", tag);
        end
        @(posedge hclk);
        if (d < 3) begin
            e.dut   = d;
            e.rdata = erd;
            e.resp  = er;
            e.waits = er ? 1 : (tr[1] ? ws_of(d) : 0);
            e.tag   = tag;
            sb.push_back(e);
        end
        pend = (tr[1] && wr) ? wd : 32'h0;
    endtask

    // Monitor: the head entry is the data phase currently on the bus
    always @(negedge hclk) begin
        exp_t e;
        #2;
        if (!hreset && sb.size() > 0) begin
            e = sb[0];
            if (!get_ro(e.dut)) begin
                lowc++;
                chk({e.tag, "_lowresp"}, {31'h0, get_rs(e.dut)}, {31'h0, e.resp});
                if (lowc > 40) begin
                    chk({e.tag, "_timeout"}, 32'h0, 32'h1);
                    void'(sb.pop_front());
                    lowc = 0;
                end
            end else begin
                void'(sb.pop_front());
                chk({e.tag, "_waits"}, 32'(lowc), 32'(e.waits));
                chk({e.tag, "_resp"}, {31'h0, get_rs(e.dut)}, {31'h0, e.resp});
                chk({e.tag, "_rdata"}, get_rd(e.dut), e.rdata);
                lowc = 0;
            end
        end
    end

    initial begin
        int budget;
        hreset = 1'b1;
        hsel   = '0;
        haddr  = '0;
        hwdata = '0;
        htrans = T_IDLE;
        hwrite = 1'b0;
        hsize  = SZ_W;
        hburst = '0;
        repeat (2) @(negedge hclk);
        #3;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_ready", d), {31'h0, get_ro(d)}, 32'h1);
            chk($sformatf("rst%0d_resp", d), {31'h0, get_rs(d)}, 32'h0);
            chk($sformatf("rst%0d_rdata", d), get_rd(d), 32'h0);
        end
        hreset = 1'b0;

        // Zero-wait slave: back-to-back write/read, byte lanes, range handling
        issue(0, T_NSEQ, 1, SZ_W, 32'h010, 32'hDEADBEEF, 32'h0, 0, "b2b_wr");
        issue(0, T_NSEQ, 0, SZ_W, 32'h010, 32'h0, 32'hDEADBEEF, 0, "b2b_rd");
        issue(0, T_NSEQ, 1, SZ_W, 32'h020, 32'h00000000, 32'h0, 0, "lane_clr");
        issue(0, T_NSEQ, 1, SZ_B, 32'h021, 32'hA5A5A5A5, 32'h0, 0, "lane_b");
        issue(0, T_NSEQ, 1, SZ_H, 32'h022, 32'h12341234, 32'h0, 0, "lane_h");
        issue(0, T_NSEQ, 0, SZ_W, 32'h020, 32'h0, 32'h1234A500, 0, "lane_rd");
        issue(0, T_NSEQ, 0, SZ_B, 32'h023, 32'h0, 32'h1234A500, 0, "lane_rdb");
        issue(0, T_NSEQ, 1, SZ_W, 32'h000, 32'h01020304, 32'h0, 0, "al_init");
`ifdef AHB_SRAM_ERR_EN
        issue(0, T_NSEQ, 1, SZ_W, 32'h400, 32'h5A5A5A5A, 32'h0, 1, "oob_wr");
        issue(0, T_NSEQ, 0, SZ_W, 32'h000, 32'h0, 32'h01020304, 0, "oob_chk");
        issue(0, T_NSEQ, 1, SZ_W, 32'h002, 32'h77777777, 32'h0, 1, "mis_wr");
        issue(0, T_NSEQ, 0, SZ_W, 32'h000, 32'h0, 32'h01020304, 0, "mis_chk");
        issue(0, T_NSEQ, 0, 3'd3, 32'h020, 32'h0, 32'h0, 1, "sz3_rd");
        issue(0, T_NSEQ, 0, SZ_H, 32'h013, 32'h0, 32'h0, 1, "mis_rdh");
`else
        issue(0, T_NSEQ, 1, SZ_W, 32'h400, 32'h5A5A5A5A, 32'h0, 0, "oob_wr");
        issue(0, T_NSEQ, 0, SZ_W, 32'h000, 32'h0, 32'h5A5A5A5A, 0, "oob_chk");
        issue(0, T_NSEQ, 1, SZ_W, 32'h002, 32'h77777777, 32'h0, 0, "mis_wr");
        issue(0, T_NSEQ, 0, SZ_W, 32'h000, 32'h0, 32'h77777777, 0, "mis_chk");
        issue(0, T_NSEQ, 0, 3'd3, 32'h020, 32'h0, 32'h1234A500, 0, "sz3_rd");
        issue(0, T_NSEQ, 0, SZ_H, 32'h013, 32'h0, 32'hDEADBEEF, 0, "mis_rdh");
`endif
        issue(3, T_IDLE, 0, SZ_W, 32'h0, 32'h0, 32'h0, 0, "flush0");

        // Two-wait slave at base 0x1000: wait count, IDLE/BUSY, wrap/error
        issue(1, T_NSEQ, 1, SZ_W, 32'h1008, 32'hCAFEF00D, 32'h0, 0, "ws_wr");
        issue(1, T_NSEQ, 0, SZ_W, 32'h1008, 32'h0, 32'hCAFEF00D, 0, "ws_rd");
        issue(1, T_IDLE, 0, SZ_W, 32'h1008, 32'h0, 32'h0, 0, "ws_idle");
        issue(1, T_BUSY, 0, SZ_W, 32'h1008, 32'h0, 32'h0, 0, "ws_busy");
`ifdef AHB_SRAM_ERR_EN
        issue(1, T_NSEQ, 0, SZ_W, 32'h1108, 32'h0, 32'h0, 1, "ws_alias");
`else
        issue(1, T_NSEQ, 0, SZ_W, 32'h1108, 32'h0, 32'hCAFEF00D, 0, "ws_alias");
`endif
        issue(3, T_IDLE, 0, SZ_W, 32'h0, 32'h0, 32'h0, 0, "flush1");

        // Three-wait slave: reset during a write's wait states drops the write
        issue(2, T_NSEQ, 1, SZ_W, 32'h040, 32'h11111111, 32'h0, 0, "rw_pre");
        issue(3, T_IDLE, 0, SZ_W, 32'h0, 32'h0, 32'h0, 0, "flush2");
        issue(2, T_NSEQ, 1, SZ_W, 32'h040, 32'h22222222, 32'h0, 0, "rw_abort");
        @(negedge hclk);
        hwdata = pend;
        hsel   = '0;
        htrans = T_IDLE;
        #3;
        hreset = 1'b1;
        sb.delete();
        lowc = 0;
        #1;
        chk("rst_async_ready", {31'h0, ro2}, 32'h1);
        @(negedge hclk);
        #3;
        chk("rst_mid_ready", {31'h0, ro2}, 32'h1);
        chk("rst_mid_resp", {31'h0, rs2}, 32'h0);
        chk("rst_mid_rdata", rd2, 32'h0);
        pend   = 32'h0;
        hreset = 1'b0;
        issue(2, T_NSEQ, 0, SZ_W, 32'h040, 32'h0, 32'h11111111, 0, "rw_post");
        issue(3, T_IDLE, 0, SZ_W, 32'h0, 32'h0, 32'h0, 0, "flush3");

        budget = 0;
        while (sb.size() > 0 && budget < 100) begin
            @(negedge hclk);
            budget++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
